// File: rtl/serial_alu_inv.sv
// ---------------------------------------------------------------------------
// serial_alu_inv
//
// Bit-serial operand-recovery unit. It undoes the team's bit-serial
// XOR/subtract ALU. Given an ALU result R and the B operand that produced it,
// the unit rebuilds the A operand one bit per cycle, LSB first:
//   opCode 001 : A = R ^ B   (inverse of XOR)
//   opCode 100 : A = R + B   (inverse of A - B, ripple add, modulo 2^WIDTH)
//   opCode 000 : abort an operation that is in progress
//   any other  : invalid; a start carrying it is ignored
//
// Ports
//   clk_i      rising-edge clock
//   reset_i    synchronous, active-high reset; has priority over all inputs
//   start_i    request; only looked at while ready_o is high
//   opCode_i   operation select (see above)
//   srcR_i     ALU result operand (WIDTH bits)
//   srcB_i     B operand (WIDTH bits)
//   ready_o    unit is idle and will accept start_i
//   done_o     one-cycle pulse: srcA_o and the flags were just updated
//   srcA_o     recovered operand (WIDTH bits)
//   zero_o     srcA_o == 0
//   carryx_o   carry out of the MSB for add, 0 for XOR
//   sign_o     srcA_o[WIDTH-1]
//
// WIDTH must be at least 2. Latency from an accepted start to done_o is WIDTH
// cycles. A start held through the done cycle is accepted straight away, so
// back-to-back operations take WIDTH+1 cycles each.
// ---------------------------------------------------------------------------
module serial_alu_inv #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       opCode_i,
  input  logic [WIDTH-1:0] srcR_i,
  input  logic [WIDTH-1:0] srcB_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] srcA_o,
  output logic             zero_o,
  output logic             carryx_o,
  output logic             sign_o
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0]       OP_ABORT = 3'b000;
  localparam logic [2:0]       OP_XOR   = 3'b001;
  localparam logic [2:0]       OP_ADD   = 3'b100;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q;

  // Operands latched at start so the unit ignores input changes while running.
  logic [WIDTH-1:0] srcR_q;
  logic [WIDTH-1:0] srcB_q;
  logic             opIsAdd_q;

  // Serial datapath state: bit index, ripple carry and the partial result.
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] shadow_q;

  // Registered outputs.
  logic [WIDTH-1:0] srcA_q;
  logic             zero_q;
  logic             carryx_q;
  logic             sign_q;
  logic             ready_q;
  logic             done_q;

  // One-bit slice of the datapath. Next-state values are derived from the
  // current index so the sequential block only decides whether to commit them.
  logic             bitR;
  logic             bitB;
  logic             sumBit;
  logic             carry_d;
  logic [WIDTH-1:0] shadow_d;

  // Bit-slice logic for the bit selected by idx_q. For XOR the carry chain is
  // forced to zero, which also makes the final carryx 0 for XOR without a
  // separate select at completion.
  always_comb begin
    bitR     = srcR_q[idx_q];
    bitB     = srcB_q[idx_q];
    sumBit   = bitR ^ bitB ^ (opIsAdd_q & carry_q);
    carry_d  = opIsAdd_q & ((bitR & bitB) | (bitR & carry_q) | (bitB & carry_q));
    shadow_d = shadow_q;
    shadow_d[idx_q] = sumBit;
  end

  // Control FSM and all registers. done_q is a pulse, so it defaults to 0
  // every cycle and is set only on the edge that computes the last bit.
  // Abort is checked before the bit step, so an abort sampled on the edge
  // that would finish the operation still suppresses done and keeps the
  // previous outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      srcR_q    <= '0;
      srcB_q    <= '0;
      opIsAdd_q <= 1'b0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      shadow_q  <= '0;
      srcA_q    <= '0;
      zero_q    <= 1'b0;
      carryx_q  <= 1'b0;
      sign_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && ((opCode_i == OP_XOR) || (opCode_i == OP_ADD))) begin
            srcR_q    <= srcR_i;
            srcB_q    <= srcB_i;
            opIsAdd_q <= (opCode_i == OP_ADD);
            idx_q     <= '0;
            carry_q   <= 1'b0;
            shadow_q  <= '0;
            ready_q   <= 1'b0;
            state_q   <= RUN;
          end
        end

        RUN: begin
          if (opCode_i == OP_ABORT) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            shadow_q <= shadow_d;
            carry_q  <= carry_d;
            idx_q    <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              srcA_q   <= shadow_d;
              zero_q   <= (shadow_d == '0);
              sign_q   <= shadow_d[WIDTH-1];
              carryx_q <= carry_d;
              idx_q    <= '0;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end

        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign srcA_o   = srcA_q;
  assign zero_o   = zero_q;
  assign carryx_o = carryx_q;
  assign sign_o   = sign_q;

endmodule

// File: tb/tb_serial_alu_inv.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_inv
//
// Directed testbench for serial_alu_inv at WIDTH=4. Each scenario task drives
// its own stimulus and compares the packed output status
// {ready, done, srcA, zero, carryx, sign} against hand-computed values.
// Inputs change #1 after a rising edge; outputs are read at that same point.
// ---------------------------------------------------------------------------
module tb_serial_alu_inv;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] opCode;
  logic [3:0] srcR;
  logic [3:0] srcB;
  logic       ready;
  logic       done;
  logic [3:0] srcA;
  logic       zero;
  logic       carryx;
  logic       sign;

  logic [8:0] obs;
  int         checks;
  int         errors;

  serial_alu_inv #(.WIDTH(4)) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .opCode_i (opCode),
    .srcR_i   (srcR),
    .srcB_i   (srcB),
    .ready_o  (ready),
    .done_o   (done),
    .srcA_o   (srcA),
    .zero_o   (zero),
    .carryx_o (carryx),
    .sign_o   (sign)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed status, bit order: ready, done, srcA[3:0], zero, carryx, sign.
  assign obs = {ready, done, srcA, zero, carryx, sign};

  // Advance past the next rising edge; inputs and checks happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    opCode = 3'b000;
    srcR   = 4'h0;
    srcB   = 4'h0;
    tick();
    tick();
    checks++;
    if (obs !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b expected %b", obs, 9'b1_0_0000_0_0_0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("[TB] FAIL reset_idle_hold: got %b expected %b", obs, 9'b1_0_0000_0_0_0);
    end
  endtask

  // 0011 + 0101 = 1000: sign set, no carry out.
  task automatic test_add();
    start  = 1'b1;
    opCode = 3'b100;
    srcR   = 4'b0011;
    srcB   = 4'b0101;
    tick();
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_ready_drop: got %b expected 0", ready);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (obs !== 9'b0_0_0000_0_0_0) begin
        errors++;
        $display("[TB] FAIL add_running_E%0d: got %b expected %b", k, obs, 9'b0_0_0000_0_0_0);
      end
    end
    tick();
    checks++;
    if (obs !== 9'b1_1_1000_0_0_1) begin
      errors++;
      $display("[TB] FAIL add_done: got %b expected %b", obs, 9'b1_1_1000_0_0_1);
    end
    tick();
    checks++;
    if (obs !== 9'b1_0_1000_0_0_1) begin
      errors++;
      $display("[TB] FAIL add_hold_after_done: got %b expected %b", obs, 9'b1_0_1000_0_0_1);
    end
  endtask

  // 1010 ^ 0110 = 1100, with the inputs scrambled while the unit is running.
  task automatic test_xor();
    start  = 1'b1;
    opCode = 3'b001;
    srcR   = 4'b1010;
    srcB   = 4'b0110;
    tick();
    start = 1'b0;
    srcR  = 4'b0101;
    srcB  = 4'b1111;
    tick();
    srcR  = 4'b0000;
    srcB  = 4'b1001;
    tick();
    srcR  = 4'b1111;
    srcB  = 4'b0011;
    tick();
    tick();
    checks++;
    if (obs !== 9'b1_1_1100_0_0_1) begin
      errors++;
      $display("[TB] FAIL xor_done: got %b expected %b", obs, 9'b1_1_1100_0_0_1);
    end
  endtask

  // 1111 + 0001 wraps to 0000 with carry out.
  task automatic test_wrap();
    start  = 1'b1;
    opCode = 3'b100;
    srcR   = 4'b1111;
    srcB   = 4'b0001;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (obs !== 9'b1_1_0000_1_1_0) begin
      errors++;
      $display("[TB] FAIL wrap_done: got %b expected %b", obs, 9'b1_1_0000_1_1_0);
    end
  endtask

  task automatic test_abort_invalid();
    int donePulses;
    start  = 1'b1;
    opCode = 3'b100;
    srcR   = 4'b0011;
    srcB   = 4'b0101;
    tick();
    start = 1'b0;
    tick();
    opCode = 3'b000;
    tick();
    checks++;
    if (obs !== 9'b1_0_0000_1_1_0) begin
      errors++;
      $display("[TB] FAIL abort_return_idle: got %b expected %b", obs, 9'b1_0_0000_1_1_0);
    end
    donePulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done === 1'b1) donePulses++;
    end
    checks++;
    if (donePulses !== 0 || obs !== 9'b1_0_0000_1_1_0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d pulses status %b expected 0 pulses status %b",
               donePulses, obs, 9'b1_0_0000_1_1_0);
    end
    start  = 1'b1;
    opCode = 3'b010;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL invalid_op_ready: got %b expected 1", ready);
    end
    start = 1'b0;
    donePulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done === 1'b1 || ready !== 1'b1) donePulses++;
    end
    checks++;
    if (donePulses !== 0) begin
      errors++;
      $display("[TB] FAIL invalid_op_ignored: got %0d bad cycles expected 0", donePulses);
    end
  endtask

  task automatic test_reset_mid_op();
    int donePulses;
    // A start during RUN must not disturb the running add of 0001 + 0010.
    start  = 1'b1;
    opCode = 3'b100;
    srcR   = 4'b0001;
    srcB   = 4'b0010;
    tick();
    opCode = 3'b001;
    srcR   = 4'b1111;
    srcB   = 4'b1111;
    tick();
    tick();
    start  = 1'b0;
    opCode = 3'b100;
    tick();
    tick();
    checks++;
    if (obs !== 9'b1_1_0011_0_0_0) begin
      errors++;
      $display("[TB] FAIL start_in_run_ignored: got %b expected %b", obs, 9'b1_1_0011_0_0_0);
    end
    tick();
    // Now reset sampled at E2 of a fresh add.
    start  = 1'b1;
    srcR   = 4'b0011;
    srcB   = 4'b0101;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: got %b expected %b", obs, 9'b1_0_0000_0_0_0);
    end
    donePulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done === 1'b1) donePulses++;
    end
    checks++;
    if (donePulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op_no_done: got %0d pulses expected 0", donePulses);
    end
    // Reset and start together: start must be dropped.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_beats_start: got ready %b expected 1", ready);
    end
  endtask

  // 0001 ^ 0001 twice with start held across the first done cycle.
  task automatic test_back_to_back();
    int donePulses;
    donePulses = 0;
    start  = 1'b1;
    opCode = 3'b001;
    srcR   = 4'b0001;
    srcB   = 4'b0001;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (done === 1'b1) donePulses++;
    end
    tick();
    if (done === 1'b1) donePulses++;
    checks++;
    if (obs !== 9'b1_1_0000_1_0_0) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got %b expected %b", obs, 9'b1_1_0000_1_0_0);
    end
    tick();
    start = 1'b0;
    checks++;
    if (obs !== 9'b0_0_0000_1_0_0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: got %b expected %b", obs, 9'b0_0_0000_1_0_0);
    end
    for (int k = 6; k <= 8; k++) begin
      tick();
      if (done === 1'b1) donePulses++;
    end
    tick();
    if (done === 1'b1) donePulses++;
    checks++;
    if (obs !== 9'b1_1_0000_1_0_0) begin
      errors++;
      $display("[TB] FAIL b2b_second_done: got %b expected %b", obs, 9'b1_1_0000_1_0_0);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done === 1'b1) donePulses++;
    end
    checks++;
    if (donePulses !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", donePulses);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_xor();
    test_wrap();
    test_abort_invalid();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
